// File: rtl/pulse_pkg.sv
// Shared widths and types for the pulse playback path.
package pulse_pkg;

    localparam int PULSE_REG_PHASE_W = 16;
    localparam int PULSE_REG_AMP_W   = 16;
    localparam int PULSE_REG_FREQ_W  = 32;
    localparam int PULSE_REG_TLEN_W  = 16;
    localparam int ENVELOPE_ADDR_W   = 10;

    // The accumulator is as wide as the frequency word; phase is its top slice.
    localparam int ACC_W = PULSE_REG_FREQ_W;

    typedef struct packed {
        logic [PULSE_REG_PHASE_W-1:0] phase;
        logic [PULSE_REG_AMP_W-1:0]   amp;
        logic [PULSE_REG_FREQ_W-1:0]  freq;
        logic [PULSE_REG_TLEN_W-1:0]  tlen;
        logic [ENVELOPE_ADDR_W-1:0]   env_addr;
    } pulse_desc_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } player_state_e;

endpackage

// File: rtl/pulse_player_if.sv
// Descriptor handshake between the pulse FIFO (master) and the player (slave).
interface pulse_player_if;
    import pulse_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic [PULSE_REG_PHASE_W-1:0] in_phase;
    logic [PULSE_REG_AMP_W-1:0]   in_amp;
    logic [PULSE_REG_FREQ_W-1:0]  in_freq;
    logic [PULSE_REG_TLEN_W-1:0]  in_tlen;
    logic [ENVELOPE_ADDR_W-1:0]   in_env_addr;

    modport master (
        output in_valid, in_phase, in_amp, in_freq, in_tlen, in_env_addr,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_phase, in_amp, in_freq, in_tlen, in_env_addr,
        output in_ready
    );

endinterface

// File: rtl/pulse_nco_acc.sv
// Phase accumulator: load places the start phase in the top bits, advance adds
// the latched increment each sample, phase taps the top PULSE_REG_PHASE_W bits.
module pulse_nco_acc
    import pulse_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         advance,
    input  logic [PULSE_REG_PHASE_W-1:0] load_phase,
    input  logic [ACC_W-1:0]             load_freq,
    output logic [PULSE_REG_PHASE_W-1:0] phase
);

    if (ACC_W < PULSE_REG_PHASE_W) begin : g_width_check
        $error("pulse_nco_acc: frequency word narrower than phase word");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] freq_r;

    // Load wins over advance so a back-to-back pulse restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            freq_r <= '0;
        end else if (load) begin
            acc    <= ACC_W'(load_phase) << (ACC_W - PULSE_REG_PHASE_W);
            freq_r <= load_freq;
        end else if (advance) begin
            acc <= acc + freq_r;
        end
    end

    assign phase = acc[ACC_W-1 -: PULSE_REG_PHASE_W];

endmodule

// File: rtl/pulse_player.sv
// Plays one pulse descriptor at a time as a stream of tlen samples: issue
// stage drives the envelope read and phase tag, stage 2 scales amplitude.
// Optional build macro PULSE_PLAYER_RECT_BYPASS_EN: env_addr all-ones selects
// a rectangular envelope (no reads, out_amp = amp).
//
// state | meaning
// IDLE  | no pulse issuing; ready for a descriptor
// PLAY  | issuing one sample per cycle of the current pulse
module pulse_player
    import pulse_pkg::*;
#(
    parameter int ENV_DATA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pulse_player_if.slave                desc,
    input  logic                         abort,
    output logic                         env_rd_en,
    output logic [ENVELOPE_ADDR_W-1:0]   env_rd_addr,
    input  logic [ENV_DATA_W-1:0]        env_rd_data,
    output logic                         out_valid,
    output logic [PULSE_REG_PHASE_W-1:0] out_phase,
    output logic [PULSE_REG_AMP_W-1:0]   out_amp,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int PROD_W = PULSE_REG_AMP_W + ENV_DATA_W;

    player_state_e state, state_nxt;
    pulse_desc_t   in_desc;

    logic [PULSE_REG_AMP_W-1:0]   amp_r;
    logic [PULSE_REG_TLEN_W-1:0]  tlen_r;
    logic [PULSE_REG_TLEN_W-1:0]  cnt;
    logic [ENVELOPE_ADDR_W-1:0]   addr_r;
    logic                         byp_r;
    logic                         byp_sel;
    logic                         issue_last;
    logic                         in_ready_w;
    logic                         accept;
    logic                         start;
    logic [PULSE_REG_PHASE_W-1:0] nco_phase;

    logic                         s1_valid;
    logic [PULSE_REG_PHASE_W-1:0] s1_phase;
    logic [PULSE_REG_AMP_W-1:0]   s1_amp;
    logic                         s1_last;
    logic                         s1_byp;
    logic [PROD_W-1:0]            prod;

    assign in_desc = '{phase:    desc.in_phase,
                       amp:      desc.in_amp,
                       freq:     desc.in_freq,
                       tlen:     desc.in_tlen,
                       env_addr: desc.in_env_addr};

`ifdef PULSE_PLAYER_RECT_BYPASS_EN
    assign byp_sel = &in_desc.env_addr;
`else
    assign byp_sel = 1'b0;
`endif

    assign issue_last    = (state == PLAY) && (cnt == tlen_r - PULSE_REG_TLEN_W'(1));
    assign in_ready_w    = (state == IDLE) || issue_last;
    assign desc.in_ready = in_ready_w;
    assign accept        = desc.in_valid && in_ready_w && !abort;
    assign start         = accept && (in_desc.tlen != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: abort beats acceptance; a zero-length accept on the last
    // issue simply ends the pulse.
    always_comb begin
        state_nxt = state;
        if (abort)           state_nxt = IDLE;
        else if (start)      state_nxt = PLAY;
        else if (issue_last) state_nxt = IDLE;
    end

    // Descriptor latch and per-sample index/address stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_r  <= '0;
            tlen_r <= '0;
            cnt    <= '0;
            addr_r <= '0;
            byp_r  <= 1'b0;
        end else if (start) begin
            amp_r  <= in_desc.amp;
            tlen_r <= in_desc.tlen;
            cnt    <= '0;
            addr_r <= in_desc.env_addr;
            byp_r  <= byp_sel;
        end else if (state == PLAY) begin
            cnt    <= cnt + PULSE_REG_TLEN_W'(1);
            addr_r <= addr_r + ENVELOPE_ADDR_W'(1);
        end
    end

    pulse_nco_acc u_nco (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start),
        .advance    (state == PLAY),
        .load_phase (in_desc.phase),
        .load_freq  (in_desc.freq),
        .phase      (nco_phase)
    );

    assign env_rd_en   = (state == PLAY) && !byp_r;
    assign env_rd_addr = addr_r;

    // Stage 1: capture the issued sample's tag while the envelope read is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_phase <= '0;
            s1_amp   <= '0;
            s1_last  <= 1'b0;
            s1_byp   <= 1'b0;
        end else begin
            s1_valid <= (state == PLAY) && !abort;
            s1_phase <= nco_phase;
            s1_amp   <= amp_r;
            s1_last  <= issue_last;
            s1_byp   <= byp_r;
        end
    end

    assign prod = PROD_W'(s1_amp) * PROD_W'(env_rd_data);

    // Stage 2: scale by the returned envelope sample and present the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_phase <= '0;
            out_amp   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= s1_valid && !abort;
            out_phase <= s1_phase;
            out_amp   <= s1_byp ? s1_amp : prod[PROD_W-1:ENV_DATA_W];
            out_last  <= s1_valid && s1_last && !abort;
        end
    end

    // One-cycle flag for a descriptor that could not be taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else        overrun <= desc.in_valid && (!in_ready_w || abort);
    end

    assign busy = (state == PLAY) || s1_valid || out_valid;

endmodule

// File: tb/tb_pulse_player.sv
// Bench for pulse_player: directed vector table, hand sequences for multi-cycle
// corners, and random traffic checked cycle by cycle against a queue model.
module tb_pulse_player;
    import pulse_pkg::*;

`ifdef PULSE_PLAYER_RECT_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic        env_rd_en;
    logic [9:0]  env_rd_addr;
    logic [15:0] env_rd_data = '0;
    logic        out_valid, out_last, busy, overrun;
    logic [15:0] out_phase, out_amp;

    pulse_player_if dif();

    pulse_player #(.ENV_DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .desc        (dif),
        .abort       (abort),
        .env_rd_en   (env_rd_en),
        .env_rd_addr (env_rd_addr),
        .env_rd_data (env_rd_data),
        .out_valid   (out_valid),
        .out_phase   (out_phase),
        .out_amp     (out_amp),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    always @(posedge clk) if (env_rd_en) env_rd_data <= mem[env_rd_addr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic [15:0] ph;
        logic [15:0] amp;
        logic        last;
    } smp_t;

    smp_t        exp_q[$];
    int          cyc = 0;
    int          rem = 0;
    logic [15:0] cur_tlen = '0;
    logic [9:0]  cur_base = '0;
    bit          cur_byp = 1'b0;
    bit          ovr_pend = 1'b0;
    bit          m_ready, m_rd;
    int          cap_cnt = 0;
    bit          cap_done = 1'b0;
    bit          busy_drop = 1'b0;
    int          rd_cnt = 0;
    logic [15:0] cap_phase, cap_amp;

    always @(posedge clk) cyc++;

    task automatic push_pulse();
        smp_t        s;
        logic [31:0] a, p;
        logic [9:0]  ad;
        bit          byp;
        byp = BYP_EN && (dif.in_env_addr == 10'h3FF);
        for (int n = 0; n < int'(dif.in_tlen); n++) begin
            a      = {dif.in_phase, 16'h0} + 32'(n) * dif.in_freq;
            ad     = dif.in_env_addr + 10'(n);
            p      = 32'(dif.in_amp) * 32'(mem[ad]);
            s.cyc  = cyc + 3 + n;
            s.ph   = a[31:16];
            s.amp  = byp ? dif.in_amp : p[31:16];
            s.last = (n == int'(dif.in_tlen) - 1);
            exp_q.push_back(s);
        end
        cur_tlen = dif.in_tlen;
        cur_base = dif.in_env_addr;
        cur_byp  = byp;
        rem      = int'(dif.in_tlen);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rem = 0;
            exp_q.delete();
            ovr_pend = 1'b0;
            cur_byp = 1'b0;
        end else begin
            chk("busy", busy, (rem > 0) || (exp_q.size() > 0));
            m_ready = (rem <= 1);
            chk("in_ready", dif.in_ready, m_ready);
            m_rd = (rem > 0) && !cur_byp;
            chk("env_rd_en", env_rd_en, m_rd);
            if (m_rd) begin
                chk("env_rd_addr", env_rd_addr, 10'(cur_base + 10'(int'(cur_tlen) - rem)));
            end
            if (env_rd_en) rd_cnt++;
            chk("overrun", overrun, ovr_pend);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("out_valid", out_valid, 1);
                chk("out_phase", out_phase, exp_q[0].ph);
                chk("out_amp", out_amp, exp_q[0].amp);
                chk("out_last", out_last, exp_q[0].last);
                void'(exp_q.pop_front());
            end else begin
                chk("out_valid", out_valid, 0);
            end
            if (out_valid) begin
                cap_cnt++;
                cap_phase = out_phase;
                cap_amp   = out_amp;
                if (out_last) cap_done = 1'b1;
            end
            if (!busy) busy_drop = 1'b1;
            // what the coming edge does
            ovr_pend = dif.in_valid && (!m_ready || abort);
            if (abort) begin
                rem = 0;
                while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            end else if (dif.in_valid && m_ready) begin
                if (dif.in_tlen != 0) push_pulse();
                else                  rem = 0;
            end else if (rem > 0) begin
                rem--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ph, input logic [31:0] fr, input logic [15:0] am,
                        input logic [15:0] tl, input logic [9:0] ad);
        dif.in_valid = 1'b1;
        dif.in_phase = ph;
        dif.in_freq = fr;
        dif.in_amp = am;
        dif.in_tlen = tl;
        dif.in_env_addr = ad;
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin tick(); k++; end
        if (busy) fail("idle_wait");
    endtask

    task automatic wait_done();
        int k = 0;
        while (!cap_done && k < 60) begin tick(); k++; end
        if (!cap_done) fail("done_wait");
    endtask

    typedef struct {
        logic [15:0] ph;
        logic [31:0] fr;
        logic [15:0] amp;
        logic [15:0] tl;
        logic [9:0]  ad;
        int          exp_n;
        logic [15:0] exp_ph;
        logic [15:0] exp_amp;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{16'h4000, 32'h0001_0000, 16'h8000, 16'd4, 10'h010, 4, 16'h4003, 16'h7FFF};
        vt[1] = '{16'hFFFF, 32'h0001_0000, 16'hFFFF, 16'd3, 10'h3FE, 3, 16'h0001, 16'h1FFF};
        vt[2] = '{16'h0000, 32'h8000_0000, 16'h1000, 16'd2, 10'h020, 2, 16'h8000, 16'h0800};
        vt[3] = '{16'h0001, 32'h0000_8000, 16'h0100, 16'd3, 10'h030, 3, 16'h0002, 16'h00FF};

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 16; i < 20; i++) mem[i] = 16'hFFFF;
        mem[10'h3FE] = 16'h8000;
        mem[10'h3FF] = 16'h4000;
        mem[10'h000] = 16'h2000;
        mem[10'h021] = 16'h8000;
        mem[10'h032] = 16'hFFFF;

        dif.in_valid = 1'b0;
        dif.in_phase = '0;
        dif.in_freq = '0;
        dif.in_amp = '0;
        dif.in_tlen = '0;
        dif.in_env_addr = '0;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_phase", out_phase, 0);
        chk("rst_out_amp", out_amp, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_env_rd_en", env_rd_en, 0);
        chk("rst_env_rd_addr", env_rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_in_ready", dif.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // directed table: count, last phase and last amp of each pulse
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            cap_cnt = 0;
            cap_done = 1'b0;
            send(vt[i].ph, vt[i].fr, vt[i].amp, vt[i].tl, vt[i].ad);
            wait_done();
            chk($sformatf("tbl%0d_count", i), cap_cnt, vt[i].exp_n);
            chk($sformatf("tbl%0d_phase", i), cap_phase, vt[i].exp_ph);
            chk($sformatf("tbl%0d_amp", i), cap_amp, vt[i].exp_amp);
        end

        // gapless back-to-back: second descriptor on the last-issue cycle
        wait_idle();
        cap_cnt = 0;
        send(16'h1000, 32'h0002_0000, 16'h4000, 16'd3, 10'h100);
        busy_drop = 1'b0;
        tick();
        tick();
        dif.in_valid = 1'b1;
        dif.in_phase = 16'h2000;
        dif.in_tlen = 16'd3;
        dif.in_env_addr = 10'h200;
        tick();
        dif.in_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_busy_drop", busy_drop, 0);
        tick();
        tick();
        chk("b2b_count", cap_cnt, 6);

        // overrun during sample 1 of 4
        wait_idle();
        cap_cnt = 0;
        cap_done = 1'b0;
        send(16'h0100, 32'h0001_0000, 16'hFFFF, 16'd4, 10'h040);
        dif.in_valid = 1'b1;
        dif.in_tlen = 16'd5;
        tick();
        dif.in_valid = 1'b0;
        chk("ovr_pulse", overrun, 1);
        tick();
        chk("ovr_clear", overrun, 0);
        wait_done();
        chk("ovr_orig_count", cap_cnt, 4);

        // tlen=0 while idle
        wait_idle();
        cap_cnt = 0;
        rd_cnt = 0;
        send(16'h0, 32'h1, 16'h1, 16'd0, 10'h050);
        chk("tlen0_ready", dif.in_ready, 1);
        repeat (5) tick();
        chk("tlen0_outputs", cap_cnt, 0);
        chk("tlen0_reads", rd_cnt, 0);

        // abort at sample 2 of 8
        wait_idle();
        send(16'h0, 32'h0100_0000, 16'h7777, 16'd8, 10'h060);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cap_cnt = 0;
        chk("abort_busy", busy, 0);
        repeat (4) tick();
        chk("abort_no_more", cap_cnt, 0);
        cap_done = 1'b0;
        send(16'h0, 32'h0100_0000, 16'h7777, 16'd2, 10'h070);
        wait_done();
        chk("abort_next_count", cap_cnt, 2);

        // asynchronous reset mid-pulse
        wait_idle();
        send(16'h3000, 32'h0001_0000, 16'h5555, 16'd8, 10'h080);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_amp", out_amp, 0);
        chk("arst_out_phase", out_phase, 0);
        chk("arst_env_rd_en", env_rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", dif.in_ready, 1);
        tick();
        cap_cnt = 0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("arst_no_partial", cap_cnt, 0);

        // all-ones envelope address
        wait_idle();
        cap_cnt = 0;
        cap_done = 1'b0;
        rd_cnt = 0;
        send(16'h0, 32'h0001_0000, 16'h1234, 16'd2, 10'h3FF);
        wait_done();
        chk("ones_count", cap_cnt, 2);
`ifdef PULSE_PLAYER_RECT_BYPASS_EN
        chk("byp_reads", rd_cnt, 0);
        chk("byp_amp", cap_amp, 16'h1234);
`else
        chk("ones_reads", rd_cnt, 2);
        chk("ones_amp", cap_amp, 16'h0246);
`endif

        // random traffic against the model
        wait_idle();
        for (int c = 0; c < 1500; c++) begin
            dif.in_valid = ($urandom_range(0, 99) < 35);
            dif.in_phase = 16'($urandom);
            dif.in_freq = $urandom;
            dif.in_amp = 16'($urandom);
            dif.in_tlen = 16'($urandom_range(0, 6));
            dif.in_env_addr = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom);
            abort = ($urandom_range(0, 99) < 3);
            tick();
        end
        dif.in_valid = 1'b0;
        abort = 1'b0;
        wait_idle();
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
